// File: rtl/bram_write_arbiter_if.sv
// Requester handshakes and BRAM Port A write bus for bram_write_arbiter.
// The master side is the requesters plus the BRAM; the slave side is the arbiter.
interface bram_write_arbiter_if #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 16
);
   logic              sa_valid;
   logic [DATA_W-1:0] sa_data;
   logic              sa_last;
   logic              sa_ready;

   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [DATA_W-1:0] ld_data;
   logic              ld_last;
   logic              ld_ready;

   logic              bram_en;
   logic              bram_we;
   logic [ADDR_W-1:0] bram_addr;
   logic [DATA_W-1:0] bram_din;

   modport master (
      output sa_valid, sa_data, sa_last,
      input  sa_ready,
      output ld_valid, ld_addr, ld_data, ld_last,
      input  ld_ready,
      input  bram_en, bram_we, bram_addr, bram_din
   );

   modport slave (
      input  sa_valid, sa_data, sa_last,
      output sa_ready,
      input  ld_valid, ld_addr, ld_data, ld_last,
      output ld_ready,
      output bram_en, bram_we, bram_addr, bram_din
   );
endinterface

// File: rtl/bram_write_arbiter.sv
// Round-robin, burst-locked arbiter sharing BRAM write Port A between SA writeback and loader.
// Optional WR_ARB_PERF_CNT_EN adds saturating stall_cnt / conflict_cnt outputs.
module bram_write_arbiter #(
   parameter int DATA_W = 256,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   bram_write_arbiter_if.slave bus,
   input  logic [ADDR_W-1:0] addr_base,
   input  logic [ADDR_W-1:0] addr_stride,
   input  logic              reset_addr_counter,
   output logic [ADDR_W-1:0] current_addr,
   output logic              write_done,
   output logic              busy
`ifdef WR_ARB_PERF_CNT_EN
   ,
   output logic [31:0]       stall_cnt,
   output logic [31:0]       conflict_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, GNT_SA, GNT_LD} state_t;

   state_t            state_q, state_d;
   logic              owner_sa_q, owner_sa_d;
   logic              sa_ready, ld_ready, sa_acc, ld_acc;
   logic [ADDR_W-1:0] sa_wr_addr;
   logic              wr_q;
   logic [ADDR_W-1:0] addr_q;
   logic [DATA_W-1:0] din_q;

   assign sa_ready = (state_q == GNT_SA);
   assign ld_ready = (state_q == GNT_LD);
   assign sa_acc   = bus.sa_valid && sa_ready;
   assign ld_acc   = bus.ld_valid && ld_ready;
   assign busy     = (state_q != IDLE);

   assign bus.sa_ready  = sa_ready;
   assign bus.ld_ready  = ld_ready;
   assign bus.bram_en   = wr_q;
   assign bus.bram_we   = wr_q;
   assign bus.bram_addr = addr_q;
   assign bus.bram_din  = din_q;

   // A reload in the same cycle as an accepted SA beat redirects that beat to addr_base.
   assign sa_wr_addr = reset_addr_counter ? addr_base : current_addr;

   always_comb begin
      state_d    = state_q;
      owner_sa_d = owner_sa_q;
      case (state_q)
         IDLE: begin
            if (bus.sa_valid && (!bus.ld_valid || !owner_sa_q))
               state_d = GNT_SA;
            else if (bus.ld_valid)
               state_d = GNT_LD;
         end
         GNT_SA: begin
            if (sa_acc && bus.sa_last) begin
               state_d    = IDLE;
               owner_sa_d = 1'b1;
            end
         end
         GNT_LD: begin
            if (ld_acc && bus.ld_last) begin
               state_d    = IDLE;
               owner_sa_d = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         owner_sa_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         owner_sa_q <= owner_sa_d;
      end
   end

   // Port A registers: address/data hold their last value when no beat is accepted.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q         <= 1'b0;
         addr_q       <= '0;
         din_q        <= '0;
         write_done   <= 1'b0;
         current_addr <= '0;
      end else begin
         wr_q       <= sa_acc || ld_acc;
         write_done <= sa_acc && bus.sa_last;
         if (sa_acc) begin
            addr_q       <= sa_wr_addr;
            din_q        <= bus.sa_data;
            current_addr <= sa_wr_addr + addr_stride;
         end else begin
            if (ld_acc) begin
               addr_q <= bus.ld_addr;
               din_q  <= bus.ld_data;
            end
            if (reset_addr_counter)
               current_addr <= addr_base;
         end
      end
   end

`ifdef WR_ARB_PERF_CNT_EN
   logic stall_cond, conflict_cond;

   assign stall_cond    = (bus.sa_valid && !sa_ready) || (bus.ld_valid && !ld_ready);
   assign conflict_cond = (state_q == IDLE) && bus.sa_valid && bus.ld_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_cnt    <= '0;
         conflict_cnt <= '0;
      end else begin
         if (stall_cond && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 32'd1;
         if (conflict_cond && (conflict_cnt != '1))
            conflict_cnt <= conflict_cnt + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_bram_write_arbiter.sv
// Directed testbench for bram_write_arbiter; define WR_ARB_PERF_CNT_EN to also check the counters.
module tb_bram_write_arbiter;
   localparam int DW = 256;
   localparam int AW = 16;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [AW-1:0] addr_base = '0;
   logic [AW-1:0] addr_stride = '0;
   logic          reset_addr_counter = 1'b0;
   logic [AW-1:0] current_addr;
   logic          write_done;
   logic          busy;
`ifdef WR_ARB_PERF_CNT_EN
   logic [31:0]   stall_cnt;
   logic [31:0]   conflict_cnt;
`endif

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] log_addr[$];
   logic [DW-1:0] log_data[$];
   logic          log_done[$];
   logic [DW-1:0] mem[int];
   int            done_total = 0;
   int            both_ready = 0;

   bram_write_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

   bram_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .bus               (bus),
      .addr_base         (addr_base),
      .addr_stride       (addr_stride),
      .reset_addr_counter(reset_addr_counter),
      .current_addr      (current_addr),
      .write_done        (write_done),
      .busy              (busy)
`ifdef WR_ARB_PERF_CNT_EN
      ,
      .stall_cnt         (stall_cnt),
      .conflict_cnt      (conflict_cnt)
`endif
   );

   always #5 clk = ~clk;

   // Port A observer, sampled shortly after each rising edge; it also acts as the BRAM model.
   always begin
      @(posedge clk);
      #2;
      if (bus.bram_en && bus.bram_we) begin
         log_addr.push_back(bus.bram_addr);
         log_data.push_back(bus.bram_din);
         log_done.push_back(write_done);
         mem[int'(bus.bram_addr)] = bus.bram_din;
      end
      if (write_done) done_total++;
      if (bus.sa_ready && bus.ld_ready) both_ready++;
   end

   function automatic logic [DW-1:0] sa_pat(input int i);
      return {16{16'(i + 1)}};
   endfunction

   function automatic logic [DW-1:0] ld_pat(input int i);
      return {8{32'hA5A5_0000 + 32'(i)}};
   endfunction

   task automatic clear_log();
      log_addr.delete();
      log_data.delete();
      log_done.delete();
   endtask

   task automatic idle_bus();
      bus.sa_valid = 1'b0;
      bus.sa_data  = '0;
      bus.sa_last  = 1'b0;
      bus.ld_valid = 1'b0;
      bus.ld_addr  = '0;
      bus.ld_data  = '0;
      bus.ld_last  = 1'b0;
   endtask

   task automatic reload_counter();
      reset_addr_counter = 1'b1;
      @(negedge clk);
      reset_addr_counter = 1'b0;
   endtask

   // Returns at the falling edge right after the beat was accepted.
   task automatic sa_beat(input logic [DW-1:0] d, input logic last);
      int n = 0;
      bus.sa_valid = 1'b1;
      bus.sa_data  = d;
      bus.sa_last  = last;
      while (bus.sa_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("[TB] FAIL sa_beat_timeout: sa_ready=%b required 1", bus.sa_ready);
      end
      @(negedge clk);
   endtask

   task automatic ld_beat(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic last);
      int n = 0;
      bus.ld_valid = 1'b1;
      bus.ld_addr  = a;
      bus.ld_data  = d;
      bus.ld_last  = last;
      while (bus.ld_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      if (n >= 20) begin
         checks++;
         errors++;
         $display("[TB] FAIL ld_beat_timeout: ld_ready=%b required 1", bus.ld_ready);
      end
      @(negedge clk);
   endtask

   task automatic test_reset();
      idle_bus();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({bus.bram_en, bus.bram_we, write_done, busy, bus.sa_ready, bus.ld_ready} !== 6'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: en/we/done/busy/sa_rdy/ld_rdy=%b required 000000",
                  {bus.bram_en, bus.bram_we, write_done, busy, bus.sa_ready, bus.ld_ready});
      end
      checks++;
      if (bus.bram_addr !== '0 || current_addr !== '0 || bus.bram_din !== '0) begin
         errors++;
         $display("[TB] FAIL reset_values: bram_addr=%h current_addr=%h din_nonzero=%b required 0",
                  bus.bram_addr, current_addr, |bus.bram_din);
      end
`ifdef WR_ARB_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0 || conflict_cnt !== 32'd0) begin
         errors++;
         $display("[TB] FAIL reset_counters: stall=%0d conflict=%0d required 0", stall_cnt, conflict_cnt);
      end
`endif
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sa_burst();
      int d0;
      int n;
      addr_base   = 16'h0000;
      addr_stride = 16'd23;
      clear_log();
      d0 = done_total;
      for (int i = 0; i < 16; i++) sa_beat(sa_pat(i), (i == 15));
      bus.sa_valid = 1'b0;
      bus.sa_last  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 16) begin
         errors++;
         $display("[TB] FAIL sa_write_count: got %0d required 16", log_addr.size());
      end
      n = (log_addr.size() < 16) ? log_addr.size() : 16;
      for (int i = 0; i < n; i++) begin
         checks++;
         if (log_addr[i] !== 16'(23 * i) || log_data[i] !== sa_pat(i) || log_done[i] !== (i == 15)) begin
            errors++;
            $display("[TB] FAIL sa_beat_%0d: addr=%h done=%b required addr=%h done=%b",
                     i, log_addr[i], log_done[i], 16'(23 * i), (i == 15));
         end
      end
      checks++;
      if (done_total - d0 != 1) begin
         errors++;
         $display("[TB] FAIL sa_done_pulses: got %0d required 1", done_total - d0);
      end
      checks++;
      if (current_addr !== 16'd368) begin
         errors++;
         $display("[TB] FAIL sa_current_addr: got %0d required 368", current_addr);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (!mem.exists(23 * i) || mem[23 * i] !== sa_pat(i)) begin
            errors++;
            $display("[TB] FAIL sa_readback_%0d: word at %0d does not hold pattern %0d", i, 23 * i, i + 1);
         end
      end
      checks++;
      if (busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL sa_busy_after: got %b required 0", busy);
      end
   endtask

   task automatic test_loader();
      int d0;
      clear_log();
      d0 = done_total;
      for (int i = 0; i < 4; i++) begin
         ld_beat(16'h0100 + 16'(i), ld_pat(i), (i == 3));
         checks++;
         if (bus.bram_en !== 1'b1 || bus.bram_addr !== 16'h0100 + 16'(i) || bus.bram_din !== ld_pat(i)) begin
            errors++;
            $display("[TB] FAIL ld_latency_%0d: en=%b addr=%h required en=1 addr=%h",
                     i, bus.bram_en, bus.bram_addr, 16'h0100 + 16'(i));
         end
      end
      bus.ld_valid = 1'b0;
      bus.ld_last  = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 4 || done_total != d0) begin
         errors++;
         $display("[TB] FAIL ld_writes: count=%0d done_pulses=%0d required 4 and 0",
                  log_addr.size(), done_total - d0);
      end
      checks++;
      if (current_addr !== 16'd368) begin
         errors++;
         $display("[TB] FAIL ld_current_addr: got %0d required 368", current_addr);
      end
   endtask

   task automatic test_back_to_back();
      logic [AW-1:0] exp_addr[5];
      exp_addr = '{16'd0, 16'd23, 16'h0200, 16'd46, 16'h0201};
      idle_bus();
      rst_n = 1'b0;
      clear_log();
      addr_base   = 16'h0000;
      addr_stride = 16'd23;
      @(negedge clk);
      both_ready = 0;
      @(negedge clk);
      rst_n = 1'b1;
      bus.sa_valid = 1'b1; bus.sa_data = sa_pat(100); bus.sa_last = 1'b0;
      bus.ld_valid = 1'b1; bus.ld_addr = 16'h0200; bus.ld_data = ld_pat(8); bus.ld_last = 1'b1;
      checks++;
      if (bus.sa_ready !== 1'b0 || bus.ld_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arb_idle_ready: sa=%b ld=%b required 0 0", bus.sa_ready, bus.ld_ready);
      end
      @(negedge clk);
      checks++;
      if (bus.sa_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arb_first_sa: sa=%b ld=%b required 1 0", bus.sa_ready, bus.ld_ready);
      end
      @(negedge clk);
      bus.sa_data = sa_pat(101); bus.sa_last = 1'b1;
      @(negedge clk);
      bus.sa_valid = 1'b0; bus.sa_last = 1'b0;
      checks++;
      if ({bus.sa_ready, bus.ld_ready, busy} !== 3'b000) begin
         errors++;
         $display("[TB] FAIL arb_bubble: sa/ld/busy=%b required 000", {bus.sa_ready, bus.ld_ready, busy});
      end
      @(negedge clk);
      checks++;
      if (bus.sa_ready !== 1'b0 || bus.ld_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arb_ld_after_bubble: sa=%b ld=%b required 0 1", bus.sa_ready, bus.ld_ready);
      end
      bus.sa_valid = 1'b1; bus.sa_data = sa_pat(102); bus.sa_last = 1'b1;
      @(negedge clk);
      bus.ld_addr = 16'h0201; bus.ld_data = ld_pat(9);
      @(negedge clk);
      checks++;
      if (bus.sa_ready !== 1'b1 || bus.ld_ready !== 1'b0) begin
         errors++;
         $display("[TB] FAIL arb_alternate_sa: sa=%b ld=%b required 1 0", bus.sa_ready, bus.ld_ready);
      end
      @(negedge clk);
      bus.sa_valid = 1'b0; bus.sa_last = 1'b0;
      @(negedge clk);
      checks++;
      if (bus.sa_ready !== 1'b0 || bus.ld_ready !== 1'b1) begin
         errors++;
         $display("[TB] FAIL arb_alternate_ld: sa=%b ld=%b required 0 1", bus.sa_ready, bus.ld_ready);
      end
      @(negedge clk);
      bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
`ifdef WR_ARB_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 32'd8 || conflict_cnt !== 32'd2) begin
         errors++;
         $display("[TB] FAIL arb_counters: stall=%0d conflict=%0d required 8 and 2", stall_cnt, conflict_cnt);
      end
`endif
      repeat (2) @(negedge clk);
      checks++;
      if (log_addr.size() != 5) begin
         errors++;
         $display("[TB] FAIL arb_write_count: got %0d required 5", log_addr.size());
      end else begin
         for (int i = 0; i < 5; i++) begin
            checks++;
            if (log_addr[i] !== exp_addr[i]) begin
               errors++;
               $display("[TB] FAIL arb_order_%0d: addr=%h required %h", i, log_addr[i], exp_addr[i]);
            end
         end
      end
      checks++;
      if (both_ready != 0) begin
         errors++;
         $display("[TB] FAIL arb_exclusive_ready: both high in %0d cycles required 0", both_ready);
      end
   endtask

   task automatic test_wrap();
      addr_base   = 16'hFFF0;
      addr_stride = 16'h0020;
      reload_counter();
      checks++;
      if (current_addr !== 16'hFFF0) begin
         errors++;
         $display("[TB] FAIL wrap_reload: current_addr=%h required fff0", current_addr);
      end
      clear_log();
      for (int i = 0; i < 3; i++) sa_beat(sa_pat(i), (i == 2));
      bus.sa_valid = 1'b0; bus.sa_last = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 3 || log_addr[0] !== 16'hFFF0 || log_addr[1] !== 16'h0010 ||
          log_addr[2] !== 16'h0030 || current_addr !== 16'h0050) begin
         errors++;
         $display("[TB] FAIL wrap_addrs: count=%0d current_addr=%h required fff0,0010,0030 then 0050",
                  log_addr.size(), current_addr);
      end
   endtask

   task automatic test_reload_mid_burst();
      int sz;
      addr_base   = 16'h1000;
      addr_stride = 16'h0008;
      reload_counter();
      clear_log();
      sa_beat(sa_pat(0), 1'b0);
      sa_beat(sa_pat(1), 1'b0);
      bus.sa_valid = 1'b0;
      sz = log_addr.size();
      for (int g = 0; g < 2; g++) begin
         @(negedge clk);
         checks++;
         if (bus.sa_ready !== 1'b1 || busy !== 1'b1 || log_addr.size() != sz) begin
            errors++;
            $display("[TB] FAIL gap_hold_%0d: sa_ready=%b busy=%b writes=%0d required 1 1 %0d",
                     g, bus.sa_ready, busy, log_addr.size(), sz);
         end
      end
      addr_base = 16'h0040;
      reset_addr_counter = 1'b1;
      sa_beat(sa_pat(2), 1'b0);
      reset_addr_counter = 1'b0;
      sa_beat(sa_pat(3), 1'b1);
      bus.sa_valid = 1'b0; bus.sa_last = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 4 || log_addr[0] !== 16'h1000 || log_addr[1] !== 16'h1008 ||
          log_addr[2] !== 16'h0040 || log_addr[3] !== 16'h0048 || current_addr !== 16'h0050) begin
         errors++;
         $display("[TB] FAIL reload_addrs: count=%0d current_addr=%h required 1000,1008,0040,0048 then 0050",
                  log_addr.size(), current_addr);
      end
   endtask

   task automatic test_async_reset();
      addr_base   = 16'h0300;
      addr_stride = 16'h0004;
      reload_counter();
      for (int i = 0; i < 3; i++) sa_beat(sa_pat(i), 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({bus.bram_en, bus.bram_we, busy, bus.sa_ready, write_done} !== 5'b0 || current_addr !== '0) begin
         errors++;
         $display("[TB] FAIL async_reset: en/we/busy/sa_rdy/done=%b current_addr=%h required 00000 0000",
                  {bus.bram_en, bus.bram_we, busy, bus.sa_ready, write_done}, current_addr);
      end
`ifdef WR_ARB_PERF_CNT_EN
      checks++;
      if (stall_cnt !== 32'd0 || conflict_cnt !== 32'd0) begin
         errors++;
         $display("[TB] FAIL async_reset_counters: stall=%0d conflict=%0d required 0", stall_cnt, conflict_cnt);
      end
`endif
      bus.sa_valid = 1'b0;
      @(negedge clk);
      clear_log();
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL post_reset_quiet: writes=%0d busy=%b required 0 0", log_addr.size(), busy);
      end
      reload_counter();
      sa_beat(sa_pat(7), 1'b0);
      sa_beat(sa_pat(8), 1'b1);
      bus.sa_valid = 1'b0; bus.sa_last = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (log_addr.size() != 2 || log_addr[0] !== 16'h0300 || log_addr[1] !== 16'h0304) begin
         errors++;
         $display("[TB] FAIL post_reset_burst: count=%0d required 2 writes at 0300,0304", log_addr.size());
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      idle_bus();
      $display("[TB] starting bram_write_arbiter tests");
      test_reset();
      test_sa_burst();
      test_loader();
      test_back_to_back();
      test_wrap();
      test_reload_mid_burst();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/bram_write_arbiter.md
Name: bram_write_arbiter

Overview:
- Shares the single BRAM write port (Port A) between two requesters:
  - the systolic-array (SA) writeback path;
  - the loader/DMA path, which preloads weights and activations.
- Generates the strided SA write address internally.
- Loader supplies explicit addresses.
- Round-robin arbitration; a grant is locked for a whole burst (until `last`).
- Registered BRAM Port A outputs feed the 256-bit BRAM. Port B (read) is untouched.

Parameters:
- DATA_W, 256, width of a BRAM word and of both requester data buses
- ADDR_W, 16, BRAM address width; all address arithmetic is modulo 2^ADDR_W

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- sa_valid  in  1  SA beat valid
- sa_data  in  DATA_W  SA beat data
- sa_last  in  1  final beat of SA burst
- sa_ready  out  1  SA beat accepted when sa_valid&sa_ready
- ld_valid  in  1  loader beat valid
- ld_addr  in  ADDR_W  loader write address
- ld_data  in  DATA_W  loader beat data
- ld_last  in  1  final beat of loader burst
- ld_ready  out  1  loader beat accepted when ld_valid&ld_ready
- addr_base  in  ADDR_W  SA address counter reload value
- addr_stride  in  ADDR_W  SA address increment per beat
- reset_addr_counter  in  1  synchronous reload of SA counter from addr_base
- bram_en  out  1  Port A enable
- bram_we  out  1  Port A write enable
- bram_addr  out  ADDR_W  Port A address
- bram_din  out  DATA_W  Port A write data
- current_addr  out  ADDR_W  next SA write address (counter value)
- write_done  out  1  one-cycle pulse: SA last beat written
- busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0; state=IDLE; current_addr=0; last_owner=LD, so SA wins the first contention.
- States: IDLE, GNT_SA, GNT_LD.
- IDLE transitions:
  - only sa_valid -> GNT_SA.
  - only ld_valid -> GNT_LD.
  - both valid -> grant the requester that is not last_owner.
  - Arbitration costs one cycle; ready signals are 0 in IDLE.
- Ready signals:
  - GNT_SA: sa_ready=1, ld_ready=0.
  - GNT_LD: ld_ready=1, sa_ready=0.
  - Ready is a registered-state decode (no combinational path from valid).
- Burst lock: the grant is held until the accepted beat with last=1. Then state -> IDLE, last_owner = that requester. There is a one-cycle bubble between bursts.
- Valid deasserted mid-burst: the grant is held, no write is issued, and the state is unchanged.
- Write latency: an accepted beat drives bram_en=bram_we=1, bram_addr and bram_din on the next clock edge (1 cycle). Otherwise bram_en=bram_we=0, and addr/din hold their last values.
- SA addressing: an accepted SA beat writes to current_addr, then current_addr += addr_stride, wrapping mod 2^ADDR_W.
- Loader addressing: ld_addr passes through, registered.
- reset_addr_counter (any state):
  - current_addr <= addr_base.
  - If an SA beat is accepted in the same cycle, that beat writes to addr_base and current_addr <= addr_base+addr_stride.
- write_done: asserted in the same cycle bram_we carries the SA last beat. Never asserted for loader bursts.
- Async reset mid-burst:
  - Immediate return to reset values.
  - The partial burst is abandoned.
  - No write is issued after reset release until a new arbitration.

Optional Feature:
- Macro WR_ARB_PERF_CNT_EN.
- Defined: adds output ports stall_cnt (32) and conflict_cnt (32), both reset to 0, saturating.
  - stall_cnt increments each cycle either requester has valid=1 and ready=0.
  - conflict_cnt increments each IDLE cycle with sa_valid and ld_valid both high.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- SA burst, 16 beats (addr_base=0, addr_stride=23, data {16{i+1}}) -> writes at 0,23,...,345; write_done exactly once, with the 16th write; current_addr=368; readback via Port B matches.
- Loader-only burst, 4 beats to ld_addr 0x100..0x103 -> bram_addr follows ld_addr 1 cycle after each accept; write_done stays 0; current_addr unchanged.
- Both valid from IDLE right after reset -> SA granted first. After its last beat: 1 idle cycle, then loader granted. Next contention -> SA again (alternation). Ready never high to both.
- Wrap: addr_base=0xFFF0, stride=0x20, 3 SA beats -> addresses 0xFFF0, 0x0010, 0x0030.
- reset_addr_counter pulsed with addr_base=0x40 on an accepted SA beat mid-burst -> that beat writes at 0x40; next beat writes at 0x40+stride.
- rst_n asserted mid SA burst -> bram_en=0, busy=0, current_addr=0 immediately. After release a fresh burst starts at the reloaded base. With WR_ARB_PERF_CNT_EN, counters read 0.
